// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch/data requester, shared memory and stall signals of the arbiter
interface unified_mem_arbiter_if #(
    parameter int AW = 8
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          pc_stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, pc_stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, pc_stall
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port memory between instruction fetch and data access
module unified_mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = 8
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          src_dm_q, src_dm_d;
    logic          last_dm_q, last_dm_d;
    logic          we_q, we_d;
    logic [AW-3:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          grant_dm;
    logic          in_acc;
    logic          unused_addr_lsbs;

    // Byte offset bits never reach the word-addressed memory.
    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

    // On a tie, data wins unless data was the most recently completed grant.
    assign grant_dm = bus.dm_req && (!bus.if_req || !last_dm_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            src_dm_q   <= 1'b0;
            last_dm_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_dm_q   <= src_dm_d;
            last_dm_q  <= last_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_dm_d   = src_dm_q;
        last_dm_d  = last_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d  = S_ACC;
                    cnt_d    = WAIT_INIT;
                    src_dm_d = grant_dm;
                    if (grant_dm) begin
                        addr_d  = bus.dm_addr[AW-1:2];
                        we_d    = bus.dm_we;
                        wdata_d = bus.dm_wdata;
                    end else begin
                        addr_d  = bus.if_addr[AW-1:2];
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            S_ACC: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (src_dm_q) dm_rdata_d = bus.mem_rdata;
                        else          if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d   = S_IDLE;
                last_dm_d = src_dm_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_acc        = (state_q == S_ACC);
    assign bus.mem_en    = in_acc;
    assign bus.mem_we    = in_acc && we_q && (cnt_q == 3'd0);
    assign bus.mem_addr  = in_acc ? addr_q : '0;
    assign bus.mem_wdata = in_acc ? wdata_q : '0;
    assign bus.if_ready  = (state_q == S_RESP) && !src_dm_q;
    assign bus.dm_ready  = (state_q == S_RESP) && src_dm_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.pc_stall  = bus.if_req && !bus.if_ready;
endmodule
